// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline interlock controller: stall-cause
// codes, mul/div sequencer states and the register-match helper.
package hazard_stall_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        STALL_NONE = 2'b00,
        STALL_LU   = 2'b01,
        STALL_BR   = 2'b10,
        STALL_MD   = 2'b11
    } stall_cause_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer matches a source operand only for a non-zero register; $0 is hardwired.
    function automatic logic reg_hit(input logic [REG_W-1:0] num_rd,
                                     input logic [REG_W-1:0] num_src);
        return (num_rd == num_src) && (num_src != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the interlock controller: ID/EX/MEM hazard inputs,
// stall controls, mul/div handshake and the profiling counter.
interface hazard_stall_ctrl_if
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic [REG_W-1:0]       id_num_rs;
    logic [REG_W-1:0]       id_num_rt;
    logic                   id_uses_rt;
    logic                   id_is_branch;
    logic                   id_is_muldiv;
    logic                   id_reads_hilo;
    logic [REG_W-1:0]       ex_num_rd;
    logic                   ex_reg_write;
    logic                   ex_mem_read;
    logic [REG_W-1:0]       mem_num_rd;
    logic                   mem_mem_read;
    logic                   kill;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   idex_flush;
    logic [1:0]             stall_cause;
    logic                   md_start;
    logic                   md_busy;
    logic                   md_done;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_num_rs, id_num_rt, id_uses_rt, id_is_branch, id_is_muldiv,
               id_reads_hilo, ex_num_rd, ex_reg_write, ex_mem_read,
               mem_num_rd, mem_mem_read, kill,
        input  pc_write, ifid_write, idex_flush, stall_cause,
               md_start, md_busy, md_done, stall_count
    );

    modport slave (
        input  id_num_rs, id_num_rt, id_uses_rt, id_is_branch, id_is_muldiv,
               id_reads_hilo, ex_num_rd, ex_reg_write, ex_mem_read,
               mem_num_rd, mem_mem_read, kill,
        output pc_write, ifid_write, idex_flush, stall_cause,
               md_start, md_busy, md_done, stall_count
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mul/div sequencer: IDLE/BUSY FSM with a down-counter that times the
// MD_LATENCY-cycle operation; a kill aborts silently without a done pulse.
module hazard_stall_ctrl_md_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    input  logic kill,
    output logic start,
    output logic busy,
    output logic done
);
    localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_LATENCY - 1);

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // State and counter registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MD_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: launch on an accepted request, count down, leave on zero or kill.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (start_req && !kill) begin
                    state_nxt_s = MD_BUSY;
                    cnt_nxt_s   = CNT_LAST;
                end else begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            MD_BUSY: begin
                if (kill || (cnt_r == {CNT_W{1'b0}})) begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = MD_BUSY;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = MD_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs: start is combinational from the request, busy/done from the state.
    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_r)
            MD_IDLE: begin
                start = !rst && start_req && !kill;
            end
            MD_BUSY: begin
                busy = 1'b1;
                done = (cnt_r == {CNT_W{1'b0}}) && !kill;
            end
            default: begin
                start = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: stalls ID on load-use, unresolved branch
// operands and busy mul/div, sequences the mul/div unit and counts stalls.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LATENCY  = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    logic                   rs_ex_s;
    logic                   rt_ex_s;
    logic                   rs_mem_s;
    logic                   rt_mem_s;
    logic                   lu_s;
    logic                   br_s;
    logic                   md_s;
    logic                   stall_s;
    logic                   start_req_s;
    logic                   md_start_s;
    logic                   md_busy_s;
    logic                   md_done_s;
    stall_cause_t           cause_s;
    logic [STALL_CNT_W-1:0] stall_count_r;

    // Hazard terms: operand matches against EX/MEM destinations, then the three stall reasons.
    always_comb begin
        rs_ex_s  = reg_hit(bus.ex_num_rd, bus.id_num_rs);
        rt_ex_s  = bus.id_uses_rt && reg_hit(bus.ex_num_rd, bus.id_num_rt);
        rs_mem_s = reg_hit(bus.mem_num_rd, bus.id_num_rs);
        rt_mem_s = bus.id_uses_rt && reg_hit(bus.mem_num_rd, bus.id_num_rt);
        lu_s     = bus.ex_mem_read && (rs_ex_s || rt_ex_s);
        br_s     = bus.id_is_branch &&
                   ((bus.ex_reg_write && (rs_ex_s || rt_ex_s)) ||
                    (bus.mem_mem_read && (rs_mem_s || rt_mem_s)));
        md_s     = (bus.id_is_muldiv || bus.id_reads_hilo) && md_busy_s;
        stall_s  = lu_s || br_s || md_s;
    end

    // Cause encoding with load-use taking precedence over branch over mul/div.
    always_comb begin
        if (lu_s) begin
            cause_s = STALL_LU;
        end else if (br_s) begin
            cause_s = STALL_BR;
        end else if (md_s) begin
            cause_s = STALL_MD;
        end else begin
            cause_s = STALL_NONE;
        end
    end

    // A mul/div in ID issues only when nothing else holds it and no flush is pending.
    assign start_req_s = bus.id_is_muldiv && !stall_s && !bus.kill;

    hazard_stall_ctrl_md_seq #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_seq (
        .clk       (clk),
        .rst       (rst),
        .start_req (start_req_s),
        .kill      (bus.kill),
        .start     (md_start_s),
        .busy      (md_busy_s),
        .done      (md_done_s)
    );

    // Stall controls; reset freezes the front end and keeps bubbles flowing into EX.
    always_comb begin
        if (rst) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_flush  = 1'b1;
            bus.stall_cause = STALL_NONE;
        end else if (stall_s) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_flush  = 1'b1;
            bus.stall_cause = cause_s;
        end else begin
            bus.pc_write    = 1'b1;
            bus.ifid_write  = 1'b1;
            bus.idex_flush  = 1'b0;
            bus.stall_cause = STALL_NONE;
        end
    end

    // Saturating profiling counter of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {STALL_CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + STALL_CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.md_start    = md_start_s;
    assign bus.md_busy     = md_busy_s;
    assign bus.md_done     = md_done_s;
    assign bus.stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: table vectors, directed
// multi-cycle sequences and random stimulus against a timeline model.
module tb_hazard_stall_ctrl;
    localparam int LAT  = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.STALL_CNT_W(CW)) bus ();

    hazard_stall_ctrl #(
        .MD_LATENCY  (LAT),
        .STALL_CNT_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, br;
        logic [4:0] ex_rd;
        logic       ex_rw, ex_mr;
        logic [4:0] mem_rd;
        logic       mem_mr;
        logic       stall;
        logic [1:0] cause;
    } vec_t;

    int tests = 0;
    int fails = 0;
    // Reference model state: cycle index, operation start time, expected count.
    int cyc   = 0;
    bit md_on = 1'b0;
    int md_t0 = 0;
    int cnt_e = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [4:0] dst, input logic [4:0] src);
        return (src != 5'd0) && (dst == src);
    endfunction

    task automatic idle_inputs();
        bus.id_num_rs = 5'd0; bus.id_num_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_is_branch = 1'b0; bus.id_is_muldiv = 1'b0; bus.id_reads_hilo = 1'b0;
        bus.ex_num_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
        bus.mem_num_rd = 5'd0; bus.mem_mem_read = 1'b0; bus.kill = 1'b0;
    endtask

    task automatic model_reset();
        cyc = 0; md_on = 1'b0; md_t0 = 0; cnt_e = 0;
    endtask

    // Called at a negedge with inputs applied: check everything, advance the model, wait one cycle.
    task automatic step(input string tag);
        bit ex_hit, mem_hit, lu, br, md, stall, done_e, start_e;
        logic [1:0] cause_e;
        #2;
        ex_hit  = m_hit(bus.ex_num_rd, bus.id_num_rs) || (bus.id_uses_rt && m_hit(bus.ex_num_rd, bus.id_num_rt));
        mem_hit = m_hit(bus.mem_num_rd, bus.id_num_rs) || (bus.id_uses_rt && m_hit(bus.mem_num_rd, bus.id_num_rt));
        lu      = bus.ex_mem_read && ex_hit;
        br      = bus.id_is_branch && ((bus.ex_reg_write && ex_hit) || (bus.mem_mem_read && mem_hit));
        md      = (bus.id_is_muldiv || bus.id_reads_hilo) && md_on;
        stall   = lu || br || md;
        cause_e = lu ? 2'b01 : br ? 2'b10 : md ? 2'b11 : 2'b00;
        done_e  = md_on && (cyc == md_t0 + LAT) && !bus.kill;
        start_e = !md_on && bus.id_is_muldiv && !stall && !bus.kill;
        chk({tag, ".pc_write"},   bus.pc_write,    !stall);
        chk({tag, ".ifid_write"}, bus.ifid_write,  !stall);
        chk({tag, ".idex_flush"}, bus.idex_flush,  stall);
        chk({tag, ".cause"},      bus.stall_cause, cause_e);
        chk({tag, ".md_start"},   bus.md_start,    start_e);
        chk({tag, ".md_busy"},    bus.md_busy,     md_on);
        chk({tag, ".md_done"},    bus.md_done,     done_e);
        chk({tag, ".count"},      bus.stall_count, cnt_e);
        if (md_on && (bus.kill || cyc == md_t0 + LAT)) md_on = 1'b0;
        if (start_e) begin
            md_on = 1'b1;
            md_t0 = cyc;
        end
        if (stall && cnt_e < CMAX) cnt_e++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".pc_write"},   bus.pc_write,    1'b0);
        chk({tag, ".ifid_write"}, bus.ifid_write,  1'b0);
        chk({tag, ".idex_flush"}, bus.idex_flush,  1'b1);
        chk({tag, ".cause"},      bus.stall_cause, 2'b00);
        chk({tag, ".md_start"},   bus.md_start,    1'b0);
        chk({tag, ".md_busy"},    bus.md_busy,     1'b0);
        chk({tag, ".md_done"},    bus.md_done,     1'b0);
        chk({tag, ".count"},      bus.stall_count, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.id_is_muldiv = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    vec_t vt[11];
    int first_start, second_start, base;

    initial begin
        idle_inputs();
        // rs rt ur br ex_rd rw mr mem_rd mmr stall cause
        vt[0]  = '{5'd8,  5'd3,  1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 2'b01};
        vt[1]  = '{5'd8,  5'd3,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 2'b00};
        vt[2]  = '{5'd9,  5'd2,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2'b10};
        vt[3]  = '{5'd0,  5'd5,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00};
        vt[4]  = '{5'd1,  5'd7,  1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00};
        vt[5]  = '{5'd1,  5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 2'b01};
        vt[6]  = '{5'd1,  5'd12, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 2'b10};
        vt[7]  = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 2'b00};
        vt[8]  = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 2'b00};
        vt[9]  = '{5'd4,  5'd6,  1'b1, 1'b0, 5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'b00};
        vt[10] = '{5'd9,  5'd6,  1'b1, 1'b1, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 2'b01};

        do_reset();

        // Combinational hazard table.
        for (int i = 0; i < 11; i++) begin
            bus.id_num_rs = vt[i].rs; bus.id_num_rt = vt[i].rt; bus.id_uses_rt = vt[i].uses_rt;
            bus.id_is_branch = vt[i].br; bus.ex_num_rd = vt[i].ex_rd; bus.ex_reg_write = vt[i].ex_rw;
            bus.ex_mem_read = vt[i].ex_mr; bus.mem_num_rd = vt[i].mem_rd; bus.mem_mem_read = vt[i].mem_mr;
            #1;
            chk($sformatf("tbl%0d.pc_write", i), bus.pc_write, !vt[i].stall);
            chk($sformatf("tbl%0d.flush", i), bus.idex_flush, vt[i].stall);
            chk($sformatf("tbl%0d.cause", i), bus.stall_cause, vt[i].cause);
            step("tbl");
        end

        // Load feeding a branch: LU now, BR next cycle, two stalls counted.
        idle_inputs();
        base = int'(bus.stall_count);
        bus.id_is_branch = 1'b1; bus.id_num_rs = 5'd9;
        bus.ex_num_rd = 5'd9; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
        #1 chk("lubr.c0.cause", bus.stall_cause, 2'b01);
        step("lubr");
        bus.ex_num_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
        bus.mem_num_rd = 5'd9; bus.mem_mem_read = 1'b1;
        #1 chk("lubr.c1.cause", bus.stall_cause, 2'b10);
        step("lubr");
        bus.mem_num_rd = 5'd0; bus.mem_mem_read = 1'b0;
        #1 chk("lubr.c2.pc_write", bus.pc_write, 1'b1);
        step("lubr");
        chk("lubr.count", bus.stall_count, base + 2);

        // mult at cycle 0, then mflo held in ID until the result is ready.
        idle_inputs();
        for (int c = 0; c <= LAT + 1; c++) begin
            bus.id_is_muldiv  = (c == 0);
            bus.id_reads_hilo = (c != 0);
            #1;
            chk($sformatf("md%0d.start", c), bus.md_start, c == 0);
            chk($sformatf("md%0d.busy", c), bus.md_busy, (c >= 1) && (c <= LAT));
            chk($sformatf("md%0d.done", c), bus.md_done, c == LAT);
            chk($sformatf("md%0d.cause", c), bus.stall_cause, ((c >= 1) && (c <= LAT)) ? 2'b11 : 2'b00);
            step("md");
        end

        // Back-to-back mults: starts are LAT+1 apart; then kill the second at cnt=2.
        idle_inputs();
        first_start = -1;
        second_start = -1;
        for (int c = 0; c < 16; c++) begin
            bus.id_is_muldiv = 1'b1;
            #1;
            if (bus.md_start === 1'b1) begin
                if (first_start < 0) first_start = c;
                else second_start = c;
            end
            step("b2b");
            if (second_start >= 0) break;
        end
        chk("b2b.gap", second_start - first_start, LAT + 1);
        idle_inputs();
        step("kill");
        bus.kill = 1'b1;
        #1 chk("kill.busy_before", bus.md_busy, 1'b1);
        chk("kill.done_suppressed", bus.md_done, 1'b0);
        step("kill");
        bus.kill = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("kill.busy_after", bus.md_busy, 1'b0);
            chk("kill.no_done", bus.md_done, 1'b0);
            step("kill");
        end
        bus.id_is_muldiv = 1'b1; bus.kill = 1'b1;
        #1 chk("kill.start_blocked", bus.md_start, 1'b0);
        step("kill");
        idle_inputs();
        step("kill");

        // Saturation of the stall counter.
        do_reset();
        bus.ex_mem_read = 1'b1; bus.ex_num_rd = 5'd3; bus.id_num_rs = 5'd3;
        repeat (CMAX) step("sat");
        chk("sat.reached", bus.stall_count, CMAX);
        repeat (3) step("sat");
        chk("sat.hold", bus.stall_count, CMAX);

        // Asynchronous reset in the middle of a mul/div.
        idle_inputs();
        bus.id_is_muldiv = 1'b1;
        step("arst");
        idle_inputs();
        step("arst");
        #3 rst = 1'b1;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random stimulus against the model.
        for (int n = 0; n < 800; n++) begin
            bus.id_num_rs     = 5'($urandom_range(0, 3));
            bus.id_num_rt     = 5'($urandom_range(0, 3));
            bus.ex_num_rd     = 5'($urandom_range(0, 3));
            bus.mem_num_rd    = 5'($urandom_range(0, 3));
            bus.id_uses_rt    = ($urandom_range(0, 1) == 1);
            bus.id_is_branch  = ($urandom_range(0, 3) == 0);
            bus.id_is_muldiv  = ($urandom_range(0, 3) == 0);
            bus.id_reads_hilo = ($urandom_range(0, 4) == 0);
            bus.ex_reg_write  = ($urandom_range(0, 1) == 1);
            bus.ex_mem_read   = ($urandom_range(0, 9) < 3);
            bus.mem_mem_read  = ($urandom_range(0, 9) < 3);
            bus.kill          = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
